// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and validity helper for the N-digit counter.
// Build option: BCD_COUNTER_SAT_EN selects saturating instead of wrapping count.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: steps its digit up or down when step_in is set and
// raises carry_o when the step rolls past 9 (up) or below 0 (down).
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d_i,
  input  logic       step_in,
  input  logic       up,
  output bcd_digit_t d_o,
  output logic       carry_o
);

  logic at_max;
  logic at_min;

  assign at_max  = (d_i == BCD_MAX);
  assign at_min  = (d_i == BCD_MIN);
  assign carry_o = step_in & (up ? at_max : at_min);

  always_comb begin
    d_o = d_i;
    if (step_in) begin
      if (up) d_o = at_max ? BCD_MIN : d_i + 4'd1;
      else    d_o = at_min ? BCD_MAX : d_i - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit packed-BCD counter with enable, up/down, checked load and wrap flag.
// Build option: BCD_COUNTER_SAT_EN saturates at all-9s/all-0s with wrap tied 0.
module bcd_counter_ndigit
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic                load_err
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                wrap_q, wrap_d;
  logic                lerr_q, lerr_d;

  logic [DIGITS:0]     step;
  logic [4*DIGITS-1:0] step_val;
  logic                load_ok;

  // step[g] ripples: digit g moves only when all lower digits roll over
  assign step[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .d_i     (count_q[4*g +: 4]),
      .step_in (step[g]),
      .up      (up),
      .d_o     (step_val[4*g +: 4]),
      .carry_o (step[g+1])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(load_val[4*i +: 4])) load_ok = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         lerr_d  = 1'b1;
    end else if (en) begin
`ifdef BCD_COUNTER_SAT_EN
      if (!step[DIGITS]) count_d = step_val;
`else
      count_d = step_val;
      wrap_d  = step[DIGITS];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Self-checking bench: 2-digit and 4-digit counters driven in lockstep,
// expectations from a decimal reference model queued per step.
module tb_bcd_counter_ndigit;

  typedef struct {
    int          m;
    logic [15:0] cnt;
    logic        wrap;
    logic        lerr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [15:0] lv;
  logic [7:0]  c2;
  logic [15:0] c4;
  logic        w2, w4, e2, e4;

  int   vecs = 0;
  int   errs = 0;
  int   m2 = 0;
  int   m4 = 0;
  exp_t q2[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  bcd_counter_ndigit #(.DIGITS(2)) u2 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (lv[7:0]),
    .count    (c2),
    .wrap     (w2),
    .load_err (e2)
  );

  bcd_counter_ndigit #(.DIGITS(4)) u4 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (lv),
    .count    (c4),
    .wrap     (w4),
    .load_err (e4)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input int m, input int nd,
                                 input logic r, input logic ld,
                                 input logic e, input logic u,
                                 input logic [15:0] v);
    exp_t x;
    int   mx;
    int   p;
    int   dec;
    logic ok;
    mx = 10 ** nd - 1;
    x.m = m;
    x.wrap = 1'b0;
    x.lerr = 1'b0;
    if (r) begin
      x.m = 0;
    end else if (ld) begin
      ok = 1'b1;
      dec = 0;
      p = 1;
      for (int i = 0; i < nd; i++) begin
        if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        dec = dec + int'(v[4*i +: 4]) * p;
        p = p * 10;
      end
      if (ok) x.m = dec;
      else    x.lerr = 1'b1;
    end else if (e) begin
      if (u) begin
        if (m == mx) begin
`ifndef BCD_COUNTER_SAT_EN
          x.m = 0;
          x.wrap = 1'b1;
`endif
        end else x.m = m + 1;
      end else begin
        if (m == 0) begin
`ifndef BCD_COUNTER_SAT_EN
          x.m = mx;
          x.wrap = 1'b1;
`endif
        end else x.m = m - 1;
      end
    end
    x.cnt = to_bcd(x.m);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic e,
                      input logic u, input logic [15:0] v);
    exp_t x;
    @(negedge clk);
    reset = r;
    load  = ld;
    en    = e;
    up    = u;
    lv    = v;
    x = model(m2, 2, r, ld, e, u, v);
    m2 = x.m;
    q2.push_back(x);
    x = model(m4, 4, r, ld, e, u, v);
    m4 = x.m;
    q4.push_back(x);
    @(posedge clk);
    #1;
    if (q2.size() == 0 || q4.size() == 0) begin
      vecs++;
      errs++;
      $error("FAIL queue empty");
    end else begin
      x = q2.pop_front();
      chk("cnt2", {8'h0, c2}, {8'h0, x.cnt[7:0]});
      chk("wrap2", {15'h0, w2}, {15'h0, x.wrap});
      chk("lerr2", {15'h0, e2}, {15'h0, x.lerr});
      x = q4.pop_front();
      chk("cnt4", c4, x.cnt);
      chk("wrap4", {15'h0, w4}, {15'h0, x.wrap});
      chk("lerr4", {15'h0, e4}, {15'h0, x.lerr});
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    up    = 1'b0;
    load  = 1'b0;
    lv    = '0;
    // reset, then 100 up-steps: 00..99,00 with wrap on 99->00
    step(1, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 1, 16'h0000);
    // down from 00 wraps to 99, then 98
    step(0, 0, 1, 0, 16'h0000);
    step(0, 0, 1, 0, 16'h0000);
    step(0, 0, 0, 0, 16'h0000);
    // load 57 then decade carry
    step(0, 1, 0, 0, 16'h0057);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'h0000);
    // invalid loads rejected
    step(0, 1, 0, 0, 16'h0057);
    step(0, 1, 0, 0, 16'h005A);
    step(0, 0, 0, 0, 16'h0000);
    step(0, 1, 1, 1, 16'h9A00);
    // load wins over en
    step(0, 1, 1, 1, 16'h0030);
    // reset mid-count at 42
    step(0, 1, 0, 0, 16'h0040);
    step(0, 0, 1, 1, 16'h0000);
    step(0, 0, 1, 1, 16'h0000);
    step(1, 0, 1, 1, 16'h0000);
    step(0, 0, 1, 0, 16'h0000);
    step(1, 1, 1, 0, 16'h0021);
    // top boundary: 99 / 9999 upward
    step(0, 1, 0, 0, 16'h9999);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'h0000);
    step(0, 1, 0, 0, 16'h0000);
    step(0, 0, 1, 0, 16'h0000);
    step(0, 0, 1, 0, 16'h0000);
    // borrow ripple across several zero digits
    step(0, 1, 0, 0, 16'h1000);
    step(0, 0, 1, 0, 16'h0000);
    step(0, 0, 1, 1, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
